// File: rtl/booth_divider.sv
// Sequential signed divider: non-restoring shift/add-subtract on an A:Q pair,
// one quotient bit per clock plus one sign/remainder correction cycle.
module booth_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done,
    output logic             busy,
    output logic             div_by_zero,
    output logic             overflow
);

    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state, state_next;
    logic [WIDTH:0]   a, a_sh, a_new, a_fix;
    logic [WIDTH-1:0] q, q_new, m, abs1, abs2, rem_mag;
    logic [CW-1:0]    count;
    logic             sign_q, sign_r, dz_pend, ovf_pend;

    assign abs1 = in1[WIDTH-1] ? -in1 : in1;
    assign abs2 = in2[WIDTH-1] ? -in2 : in2;

    // A's sign decides subtract vs add; A is sized so 2A never overflows.
    always_comb begin
        a_sh    = {a[WIDTH-1:0], q[WIDTH-1]};
        a_new   = a[WIDTH] ? a_sh + {1'b0, m} : a_sh - {1'b0, m};
        q_new   = {q[WIDTH-2:0], ~a_new[WIDTH]};
        a_fix   = a[WIDTH] ? a + {1'b0, m} : a;
        rem_mag = dz_pend ? q : a_fix[WIDTH-1:0];
    end

    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        case (state)
            IDLE, DONE: if (start) state_next = (in2 == '0) ? FIX : ITER;
            ITER:       if (count == CW'(1)) state_next = FIX;
            FIX:        state_next = DONE;
            default:    state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a           <= '0;
            q           <= '0;
            m           <= '0;
            count       <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            dz_pend     <= 1'b0;
            ovf_pend    <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            done        <= 1'b0;
            busy        <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a           <= '0;
                        q           <= abs1;
                        m           <= abs2;
                        count       <= CW'(WIDTH);
                        sign_q      <= in1[WIDTH-1] ^ in2[WIDTH-1];
                        sign_r      <= in1[WIDTH-1];
                        dz_pend     <= (in2 == '0);
                        ovf_pend    <= (in1 == MOST_NEG) && (in2 == '1);
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                    end
                end
                ITER: begin
                    a     <= a_new;
                    q     <= q_new;
                    count <= count - CW'(1);
                end
                FIX: begin
                    // Divide-by-zero reuses Q (= |in1|) so the remainder restores in1.
                    a           <= a_fix;
                    quotient    <= dz_pend ? '1 : (sign_q ? -q : q);
                    remainder   <= sign_r ? -rem_mag : rem_mag;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    div_by_zero <= dz_pend;
                    overflow    <= ovf_pend;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_divider.sv
// Self-checking bench for booth_divider: table vectors, random vectors checked
// against a truncating-division model, and start-held / mid-run reset sequences.
module tb_booth_divider;

    localparam int W = 16;

    typedef struct {
        logic [W-1:0] in1;
        logic [W-1:0] in2;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         ovf;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] in1 = '0, in2 = '0;
    logic [W-1:0] quotient, remainder;
    logic         done, busy, div_by_zero, overflow;

    int   checks = 0;
    int   errors = 0;
    vec_t sb[$];
    vec_t table_v[12];

    booth_divider #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in1(in1), .in2(in2),
        .quotient(quotient), .remainder(remainder), .done(done), .busy(busy),
        .div_by_zero(div_by_zero), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        vec_t v;
        logic signed [W-1:0] sa, sbv;
        sa = a;
        sbv = b;
        v.in1 = a;
        v.in2 = b;
        v.q   = sa / sbv;
        v.r   = sa % sbv;
        v.dz  = 1'b0;
        v.ovf = 1'b0;
        return v;
    endfunction

    task automatic compare_result(input string tag);
        vec_t e;
        e = sb.pop_front();
        check({tag, " quotient"},  {16'h0, quotient},  {16'h0, e.q});
        check({tag, " remainder"}, {16'h0, remainder}, {16'h0, e.r});
        check({tag, " dz"},        {31'h0, div_by_zero}, {31'h0, e.dz});
        check({tag, " ovf"},       {31'h0, overflow},    {31'h0, e.ovf});
        check({tag, " busy"},      {31'h0, busy},        32'h0);
    endtask

    // Launches one operation, waits for done with a cycle budget, checks latency.
    task automatic do_op(input vec_t e, input string tag);
        int edges;
        @(negedge clk);
        in1 = e.in1;
        in2 = e.in2;
        start = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        check({tag, " accept busy"}, {31'h0, busy}, 32'h1);
        check({tag, " accept clr"}, {29'h0, done, div_by_zero, overflow}, 32'h0);
        edges = 0;
        while (edges < 100) begin
            @(negedge clk);
            edges++;
            if (done) break;
        end
        check({tag, " latency"}, edges, (e.dz ? 1 : W + 1));
        compare_result(tag);
    endtask

    initial begin
        table_v[0]  = '{16'd100,  16'd7,    16'h000E, 16'h0002, 1'b0, 1'b0};
        table_v[1]  = '{16'hFF9C, 16'd7,    16'hFFF2, 16'hFFFE, 1'b0, 1'b0};
        table_v[2]  = '{16'd100,  16'hFFF9, 16'hFFF2, 16'h0002, 1'b0, 1'b0};
        table_v[3]  = '{16'hFF9C, 16'hFFF9, 16'h000E, 16'hFFFE, 1'b0, 1'b0};
        table_v[4]  = '{16'd5,    16'd0,    16'hFFFF, 16'h0005, 1'b1, 1'b0};
        table_v[5]  = '{16'd6,    16'd3,    16'h0002, 16'h0000, 1'b0, 1'b0};
        table_v[6]  = '{16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 1'b1};
        table_v[7]  = '{16'h7FFF, 16'd1,    16'h7FFF, 16'h0000, 1'b0, 1'b0};
        table_v[8]  = '{16'd3,    16'h7FFF, 16'h0000, 16'h0003, 1'b0, 1'b0};
        table_v[9]  = '{16'h8000, 16'd7,    16'hEDB7, 16'hFFFF, 1'b0, 1'b0};
        table_v[10] = '{16'h8000, 16'd0,    16'hFFFF, 16'h8000, 1'b1, 1'b0};
        table_v[11] = '{16'd0,    16'd5,    16'h0000, 16'h0000, 1'b0, 1'b0};

        #12;
        check("reset outputs", {quotient, remainder}, 32'h0);
        check("reset flags", {28'h0, done, busy, div_by_zero, overflow}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) do_op(table_v[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 8; i++) begin
            logic [W-1:0] a, b;
            a = W'($urandom);
            b = W'($urandom);
            if (b == '0) b = 16'd1;
            if (a == 16'h8000 && b == 16'hFFFF) b = 16'd2;
            do_op(model(a, b), $sformatf("rand%0d", i));
        end

        // DONE holds with start low.
        repeat (3) @(negedge clk);
        check("done hold", {31'h0, done}, 32'h1);

        // Start held high; operands changed mid-run must not disturb the result.
        @(negedge clk);
        in1 = 16'd100;
        in2 = 16'd7;
        start = 1'b1;
        sb.push_back(table_v[0]);
        repeat (3) @(negedge clk);
        in1 = 16'd50;
        in2 = 16'd5;
        begin
            int edges;
            edges = 2;
            while (edges < 100) begin
                @(negedge clk);
                edges++;
                if (done) break;
            end
            check("held latency", edges, W + 1);
        end
        compare_result("held");
        @(negedge clk);
        check("held reaccept", {30'h0, done, busy}, 32'h1);
        check("held q kept", {16'h0, quotient}, 32'h000E);

        // Abort in the fifth ITER cycle of the re-accepted 50/5.
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort outputs", {quotient, remainder}, 32'h0);
        check("abort flags", {28'h0, done, busy, div_by_zero, overflow}, 32'h0);
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        do_op(table_v[5], "post reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/booth_divider.md
Name: booth_divider

Overview:
- Sequential signed integer divider; the inverse datapath of the team's Booth multiplier.
- Shares the same start/done handshake, so a controller can time-multiplex multiply and divide on one operand bus.
- Uses a non-restoring shift/add-subtract algorithm with an A:Q register pair: one quotient bit per clock, then one correction cycle.
- Quotient truncates toward zero; the remainder takes the sign of the dividend.

Parameters:
- WIDTH, 16, operand width in bits for dividend, divisor, quotient and remainder (minimum 4).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled on the rising edge of clk.
- in1  input  WIDTH  dividend, signed two's complement.
- in2  input  WIDTH  divisor, signed two's complement.
- quotient  output  WIDTH  signed quotient, registered.
- remainder  output  WIDTH  signed remainder, registered.
- done  output  1  result valid (level).
- busy  output  1  operation in progress.
- div_by_zero  output  1  last operation had in2 == 0.
- overflow  output  1  last operation was most-negative / -1.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: all outputs 0, state IDLE, internal A/Q/M/count cleared. Asserting rst_n low mid-operation aborts immediately; no partial result is kept.
- States: IDLE, ITER, FIX, DONE.
- Accept rule:
  - A start is accepted on an edge with start=1 while in IDLE or DONE.
  - On that edge: in1/in2 are captured; sign_q = in1[MSB]^in2[MSB]; sign_r = in1[MSB]; busy=1; done=0; both flags clear.
  - start during ITER or FIX is ignored, and the operands are not re-sampled.
- Normal path:
  - Load A (WIDTH+1 bits) = 0, Q = |in1|, M = |in2|, count = WIDTH. Magnitudes are unsigned WIDTH-bit, so |most-negative| = 2^(WIDTH-1) is representable.
  - Next state is ITER.
- ITER, one edge per quotient bit:
  - Shift A:Q left by 1.
  - If A was non-negative, A = A - M; otherwise A = A + M.
  - Set Q[0] = ~A_new[MSB].
  - Decrement count. Leave ITER after exactly WIDTH edges.
- FIX, single edge:
  - If A is negative, A = A + M.
  - quotient = sign_q ? -Q : Q; remainder = sign_r ? -A[WIDTH-1:0] : A[WIDTH-1:0].
  - busy=0, done=1, then DONE.
- Latency: with the accept edge as edge 0, done reads 1 after edge WIDTH+1 (17 for the default).
- DONE:
  - Outputs, done and flags hold until the next accepted start.
  - A start in DONE clears done on that same edge, so back-to-back operations need no idle cycle.
  - With start=0, DONE is held indefinitely; there is no return to IDLE.
- Divide by zero (in2 == 0 at accept):
  - ITER is skipped; the block goes straight to FIX-equivalent output on edge 1.
  - quotient = all ones (-1), remainder = in1, div_by_zero=1, done=1.
  - Latency is 1 cycle.
- Overflow (in1 = -2^(WIDTH-1), in2 = -1):
  - Runs the normal path.
  - Result wraps: quotient = 2^(WIDTH-1) bit pattern, remainder = 0.
  - overflow=1 is flagged when written in FIX.
- Width rules: all negation is two's complement, truncated to WIDTH bits. A carries one extra sign bit internally and is never exposed.

Test Plan:
- in1=100, in2=7, pulse start -> after 17 cycles done=1, quotient=14 (0x000E), remainder=2, busy low, flags 0.
- in1=-100, in2=7 -> quotient=-14 (0xFFF2), remainder=-2 (0xFFFE). Then in1=100, in2=-7 -> quotient=0xFFF2, remainder=2. Then -100/-7 -> quotient=14, remainder=0xFFFE.
- in1=5, in2=0 -> done one cycle after accept, quotient=0xFFFF, remainder=5, div_by_zero=1. Then 6/3 -> div_by_zero cleared, quotient=2, remainder=0.
- in1=0x8000, in2=0xFFFF -> quotient=0x8000, remainder=0, overflow=1.
- in1=0x7FFF, in2=1 and in1=3, in2=0x7FFF -> 0x7FFF r0, and 0 r3 respectively.
- Start held high continuously, with in1/in2 changed mid-run:
  - Results use the operands captured at accept.
  - A new accept happens on the edge where done would otherwise hold.
  - Then drop rst_n at ITER cycle 5 -> all outputs 0 asynchronously, IDLE; the next start runs cleanly.
